// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, counter width.
package mdu_pkg;

    localparam int CNT_W = 6;

    localparam logic [3:0] OP_MULT  = 4'h0;
    localparam logic [3:0] OP_MULTU = 4'h1;
    localparam logic [3:0] OP_DIV   = 4'h2;
    localparam logic [3:0] OP_DIVU  = 4'h3;
    localparam logic [3:0] OP_MTHI  = 4'h4;
    localparam logic [3:0] OP_MTLO  = 4'h5;
    localparam logic [3:0] OP_MADD  = 4'h6;
    localparam logic [3:0] OP_MADDU = 4'h7;
    localparam logic [3:0] OP_MSUB  = 4'h8;
    localparam logic [3:0] OP_MSUBU = 4'h9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_div_core.sv
// Combinational signed/unsigned divider, including divide-by-zero and signed overflow handling.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    // Divide magnitudes and reapply signs; the most-negative / -1 case wraps back to itself with remainder 0.
    always_comb begin
        a_neg  = is_signed & a[WIDTH-1];
        b_neg  = is_signed & b[WIDTH-1];
        a_mag  = a_neg ? (~a + 1'b1) : a;
        b_mag  = b_neg ? (~b + 1'b1) : b;
        b_safe = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        if (b == '0) begin
            quot = '1;
            rem  = a;
        end else begin
            quot = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
            rem  = a_neg ? (~r_mag + 1'b1) : r_mag;
        end
    end

endmodule

// File: rtl/mdu_param.sv
// Multi-cycle HI/LO multiply/divide unit with fixed latencies.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_param
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    state_e             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   pend_hi, pend_hi_n;
    logic [WIDTH-1:0]   pend_lo, pend_lo_n;
    logic [WIDTH-1:0]   hi_n, lo_n;
    logic               done_n;

    logic               mul_signed;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   div_quot;
    logic [WIDTH-1:0]   div_rem;

    // Sign- or zero-extend to 2*WIDTH so one truncated multiply serves both signednesses.
    always_comb begin
        mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
        a_ext      = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext      = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        product    = a_ext * b_ext;
    end

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .a         (a),
        .b         (b),
        .is_signed (op == OP_DIV),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            hi      <= hi_n;
            lo      <= lo_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        hi_n      = hi;
        lo_n      = lo;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            {pend_hi_n, pend_lo_n} = product;
                            state_n = MUL_RUN;
                            cnt_n   = MUL_CNT;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_n = div_rem;
                            pend_lo_n = div_quot;
                            state_n   = DIV_RUN;
                            cnt_n     = DIV_CNT;
                        end
                        OP_MTHI: hi_n = a;
                        OP_MTLO: lo_n = a;
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU: begin
                            {pend_hi_n, pend_lo_n} = {hi, lo} + product;
                            state_n = MUL_RUN;
                            cnt_n   = MUL_CNT;
                        end
                        OP_MSUB, OP_MSUBU: begin
                            {pend_hi_n, pend_lo_n} = {hi, lo} - product;
                            state_n = MUL_RUN;
                            cnt_n   = MUL_CNT;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            MUL_RUN, DIV_RUN: begin
                // The last busy cycle commits; any start seen here is dropped since we are not IDLE.
                if (cnt == CNT_W'(1)) begin
                    hi_n    = pend_hi;
                    lo_n    = pend_lo;
                    cnt_n   = '0;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mdu_param.sv
// Self-checking bench for mdu_param: directed corner cases plus randomized ops against a behavioural model.
module tb_mdu_param;
    import mdu_pkg::*;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mh;
    logic [31:0] ml;

    typedef struct {
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] eh;
        logic [31:0] el;
        int          lat;
    } vec_t;

    mdu_param #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Architectural model: new HI/LO and latency from plain 64-bit arithmetic.
    function automatic void model_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                     inout logic [31:0] h, inout logic [31:0] l, output int lat);
        longint sx, sy;
        logic [63:0] acc;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        acc = {h, l};
        lat = 0;
        case (o)
            OP_MULT:  begin acc = 64'(sx * sy); lat = MUL_LAT; end
            OP_MULTU: begin acc = {32'd0, x} * {32'd0, y}; lat = MUL_LAT; end
            OP_DIV: begin
                lat = DIV_LAT;
                if (y == 0) acc = {x, 32'hFFFFFFFF};
                else if (sx == -64'sd2147483648 && sy == -64'sd1) acc = {32'd0, 32'h80000000};
                else acc = {32'(sx % sy), 32'(sx / sy)};
            end
            OP_DIVU: begin
                lat = DIV_LAT;
                if (y == 0) acc = {x, 32'hFFFFFFFF};
                else acc = {x % y, x / y};
            end
            OP_MTHI: acc = {x, l};
            OP_MTLO: acc = {h, x};
`ifdef MDU_MADD_EN
            OP_MADD:  begin acc = acc + 64'(sx * sy); lat = MUL_LAT; end
            OP_MADDU: begin acc = acc + {32'd0, x} * {32'd0, y}; lat = MUL_LAT; end
            OP_MSUB:  begin acc = acc - 64'(sx * sy); lat = MUL_LAT; end
            OP_MSUBU: begin acc = acc - {32'd0, x} * {32'd0, y}; lat = MUL_LAT; end
`endif
            default: ;
        endcase
        h = acc[63:32];
        l = acc[31:0];
    endfunction

    // Issue one op and observe busy length, done pulses and HI/LO stability while busy.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int nbusy, output int ndone, output int nhold);
        logic [31:0] ph, pl;
        @(negedge clk);
        ph = hi; pl = lo;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0; ndone = 0; nhold = 0;
        while (busy && nbusy < 70) begin
            nbusy++;
            if (done) ndone++;
            if (hi !== ph || lo !== pl) nhold++;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mh = '0;
        ml = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_lo got %h want 0", lo); end
        reset = 1'b1;
    endtask

    task automatic test_directed();
        vec_t dir[4];
        int nb, nd, nh;
        dir[0] = '{OP_MULT, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT};
        dir[1] = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
        dir[2] = '{OP_DIVU, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, DIV_LAT};
        dir[3] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DIV_LAT};
        for (int i = 0; i < 4; i++) begin
            issue(dir[i].o, dir[i].x, dir[i].y, nb, nd, nh);
            vectors++; if (nb != dir[i].lat) begin miscompares++; $display("[TB] FAIL dir%0d_busy_cycles got %0d want %0d", i, nb, dir[i].lat); end
            vectors++; if (nd != 1) begin miscompares++; $display("[TB] FAIL dir%0d_done_pulses got %0d want 1", i, nd); end
            vectors++; if (nh != 0) begin miscompares++; $display("[TB] FAIL dir%0d_hold got %0d changes want 0", i, nh); end
            vectors++; if (hi !== dir[i].eh) begin miscompares++; $display("[TB] FAIL dir%0d_hi got %h want %h", i, hi, dir[i].eh); end
            vectors++; if (lo !== dir[i].el) begin miscompares++; $display("[TB] FAIL dir%0d_lo got %h want %h", i, lo, dir[i].el); end
        end
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [31:0] x, y;
        int lat, nb, nd, nh, sel;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            o   = 4'($urandom_range(0, 15));
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = '0;
            else if (sel == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            else if (sel == 2) y = 32'($urandom_range(1, 20));
            model_op(o, x, y, mh, ml, lat);
            issue(o, x, y, nb, nd, nh);
            vectors++; if (nb != lat) begin miscompares++; $display("[TB] FAIL rnd%0d_busy_cycles op=%0d got %0d want %0d", i, o, nb, lat); end
            vectors++; if (nd != ((lat > 0) ? 1 : 0)) begin miscompares++; $display("[TB] FAIL rnd%0d_done_pulses op=%0d got %0d want %0d", i, o, nd, (lat > 0) ? 1 : 0); end
            vectors++; if (nh != 0) begin miscompares++; $display("[TB] FAIL rnd%0d_hold op=%0d got %0d changes want 0", i, o, nh); end
            vectors++; if (hi !== mh) begin miscompares++; $display("[TB] FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, o, x, y, hi, mh); end
            vectors++; if (lo !== ml) begin miscompares++; $display("[TB] FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, o, x, y, lo, ml); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y, eh, el;
        int lat;
        x = $urandom; y = $urandom;
        eh = hi; el = lo;
        model_op(OP_MULTU, x, y, eh, el, lat);
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = x; b = y;
        for (int i = 1; i <= MUL_LAT; i++) begin
            @(negedge clk);
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_busy_cycle%0d got %b want 1", i, busy); end
            start = 1'b1;
            op    = (i == MUL_LAT) ? OP_DIVU : OP_MTHI;
            a     = $urandom;
            b     = 32'd3;
        end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_commit_start_dropped busy got %b want 0", busy); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_done got %b want 1", done); end
        vectors++; if (hi !== eh) begin miscompares++; $display("[TB] FAIL b2b_hi got %h want %h", hi, eh); end
        start = 1'b1; op = OP_MTLO; a = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (lo !== 32'h1234) begin miscompares++; $display("[TB] FAIL b2b_mtlo_lo got %h want 00001234", lo); end
        vectors++; if (hi !== eh) begin miscompares++; $display("[TB] FAIL b2b_mtlo_hi got %h want %h", hi, eh); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_mtlo_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_mtlo_done got %b want 0", done); end
    endtask

    task automatic test_reset_mid();
        int nd, nbusy;
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'hA5A5A5A5;
        @(negedge clk);
        op = OP_MTLO; a = 32'h5A5A5A5A;
        @(negedge clk);
        op = OP_DIVU; a = 32'd1000; b = 32'd7;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("[TB] FAIL rstmid_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'd0) begin miscompares++; $display("[TB] FAIL rstmid_lo got %h want 0", lo); end
        nd = 0; nbusy = 0;
        for (int i = 0; i < DIV_LAT + 3; i++) begin
            if (done) nd++;
            if (busy) nbusy++;
            @(negedge clk);
        end
        vectors++; if (nd != 0) begin miscompares++; $display("[TB] FAIL rstmid_done_pulses got %0d want 0", nd); end
        vectors++; if (nbusy != 0) begin miscompares++; $display("[TB] FAIL rstmid_busy_after got %0d cycles want 0", nbusy); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd0) begin miscompares++; $display("[TB] FAIL rstmid_hilo_after got %h_%h want 0_0", hi, lo); end
    endtask

    task automatic test_madd();
        int nb, nd, nh;
        logic [31:0] eh, el;
        int elat, edone;
        do_reset();
        issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, nb, nd, nh);
        issue(OP_MADDU, 32'd1, 32'd1, nb, nd, nh);
`ifdef MDU_MADD_EN
        eh = 32'd1; el = 32'd0; elat = MUL_LAT; edone = 1;
`else
        eh = 32'd0; el = 32'hFFFFFFFF; elat = 0; edone = 0;
`endif
        vectors++; if (hi !== eh) begin miscompares++; $display("[TB] FAIL maddu_hi got %h want %h", hi, eh); end
        vectors++; if (lo !== el) begin miscompares++; $display("[TB] FAIL maddu_lo got %h want %h", lo, el); end
        vectors++; if (nb != elat) begin miscompares++; $display("[TB] FAIL maddu_busy_cycles got %0d want %0d", nb, elat); end
        vectors++; if (nd != edone) begin miscompares++; $display("[TB] FAIL maddu_done_pulses got %0d want %0d", nd, edone); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_madd();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu_param.md
MDU_PARAM -- requirements
Module: mdu_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width in bits, minimum 8.
REQ-002 SHALL have parameter MUL_LAT, default 5: cycles from multiply accept to commit, range 1..63.
REQ-003 SHALL have parameter DIV_LAT, default 10: cycles from divide accept to commit, range 1..63.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: request to issue op this cycle.
REQ-007 SHALL have port op, input, 4 bits: operation code, encodings from the shared package.
REQ-008 SHALL have port a, input, WIDTH bits: operand A (rs value, or the source for MTHI/MTLO).
REQ-009 SHALL have port b, input, WIDTH bits: operand B (rt value).
REQ-010 SHALL have port busy, output, 1 bit: a multiply or divide is in flight.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse in the cycle after HI/LO commit.
REQ-012 SHALL have port hi, output, WIDTH bits: current architectural HI.
REQ-013 SHALL have port lo, output, WIDTH bits: current architectural LO.

Function
REQ-014 SHALL implement a state machine with states IDLE, MUL_RUN and DIV_RUN.
REQ-015 SHALL accept an op only when start=1 and state is IDLE; start while busy is ignored, with no effect and no queuing.
REQ-016 SHALL, for MULT/MULTU on accept, latch the 2*WIDTH signed/unsigned product, enter MUL_RUN and load the counter with MUL_LAT.
REQ-017 SHALL, for DIV/DIVU on accept, latch quotient→LO and remainder→HI (truncating toward zero; remainder takes the dividend's sign), enter DIV_RUN and load the counter with DIV_LAT.
REQ-018 SHALL, on divide by zero, produce LO = all-ones and HI = a.
REQ-019 SHALL, on signed DIV of -2^(WIDTH-1) by -1, produce LO = -2^(WIDTH-1) and HI = 0.
REQ-020 SHALL decrement the counter each cycle in a RUN state; on the edge where the counter reaches 0, commit pending HI/LO, return to IDLE and assert done for the following cycle only.
REQ-021 SHALL assert busy during exactly MUL_LAT (or DIV_LAT) consecutive cycles, beginning the cycle after accept.
REQ-022 SHALL hold hi/lo at their old values while busy.
REQ-023 SHALL execute MTHI/MTLO only in IDLE: a written to HI or LO at the accept edge, busy never asserted, done not pulsed.
REQ-024 SHALL treat undefined op codes with start=1 as no-ops.
REQ-025 SHALL, when the counter reaches 0 and start=1 arrive in the same cycle, ignore that start; the next op is accepted at the earliest in the following (IDLE) cycle.

Reset
REQ-026 SHALL, on reset=0 at a clock edge, clear hi, lo, the pending registers and the counter to 0, force IDLE, and drive busy=0 and done=0.
REQ-027 SHALL, on reset mid-operation, discard the in-flight result; HI/LO SHALL read 0 afterward.

Configuration
REQ-028 SHALL, with macro MDU_MADD_EN defined, support MADD/MADDU/MSUB/MSUBU: {HI,LO} ± product, modulo 2^(2*WIDTH), using MUL_LAT and the same commit rules.
REQ-029 SHALL, without MDU_MADD_EN, treat these four op codes as no-ops per REQ-024.

Structure
REQ-030 SHALL place op encodings, the state enum and the counter width constant (6 bits) in package mdu_pkg.
REQ-031 SHALL isolate the signed/unsigned divide and its corner cases in one sub-module, mdu_div_core (combinational, WIDTH-parametrised).

Verification
REQ-032 SHALL verify MULT with WIDTH=32 and MUL_LAT=5: a=0xFFFFFFFE, b=3 → busy held for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulsed once.
REQ-033 SHALL verify DIV: a=-7, b=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with a=7, b=0 → LO=0xFFFFFFFF, HI=7.
REQ-034 SHALL verify the overflow case: DIV of a=0x80000000 by b=0xFFFFFFFF → LO=0x80000000, HI=0.
REQ-035 SHALL verify that start asserted during busy is ignored and a start in the commit cycle is dropped; MTLO of a=0x1234 on the next IDLE cycle → LO=0x1234, HI unchanged.
REQ-036 SHALL verify that reset=0 in the 3rd busy cycle of DIVU → HI=LO=0, busy=0, done never pulses.
REQ-037 SHALL verify, with MDU_MADD_EN and HI=0, LO=0xFFFFFFFF: MADDU with a=1, b=1 → HI=1, LO=0; and that without the macro the same op leaves HI/LO unchanged.
